register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every register in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; register count DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1, SHALL make register 0 read as all-zero and ignore writes to it when 1.
REQ-004 Parameter BYPASS, default 1, SHALL forward same-cycle write data to matching read ports when 1.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  reset, synchronous, active-high; clock clock.
REQ-007 we  input  1  write enable, sampled at the rising edge.
REQ-008 wa  input  ADDR_WIDTH  write address.
REQ-009 wd  input  WIDTH  write data.
REQ-010 ra0  input  ADDR_WIDTH  read address, port 0.
REQ-011 rd0  output  WIDTH  read data, port 0, combinational.
REQ-012 ra1  input  ADDR_WIDTH  read address, port 1.
REQ-013 rd1  output  WIDTH  read data, port 1, combinational.
REQ-014 ra_dbg  input  ADDR_WIDTH  debug read address, never bypassed.
REQ-015 rd_dbg  output  WIDTH  debug read data, combinational.

Function
REQ-016 Storage SHALL be DEPTH registers of WIDTH bits each, updated only on rising clock edges.
REQ-017 With reset low, we high and write not suppressed by REQ-019, register[wa] SHALL take wd at the edge; all other registers hold.
REQ-018 With we low, no register SHALL change.
REQ-019 With ZERO_REG=1 and wa=0, the write SHALL be discarded and register 0 SHALL stay 0.
REQ-020 rdN SHALL equal register[raN] combinationally, with zero added latency from address change.
REQ-021 With ZERO_REG=1 and raN=0, rdN SHALL be 0 regardless of we, wa, wd or BYPASS.
REQ-022 With BYPASS=1, we=1, raN=wa, reset low and the write not suppressed by REQ-019, rdN SHALL equal wd in the same cycle.
REQ-023 With BYPASS=0, rdN SHALL show the old register value until the edge, then the new value.
REQ-024 ra0=ra1 SHALL return identical data on both ports, including bypass cases.
REQ-025 rd_dbg SHALL equal register[ra_dbg]; REQ-021 applies, REQ-022 never does.
REQ-026 Addresses SHALL be full-range decoded; no out-of-range case exists and no address aliasing is permitted.
REQ-027 Back-to-back writes to the same address SHALL leave the last written value; each intermediate value is visible for exactly one cycle.

Reset
REQ-028 reset high at a rising edge SHALL clear all DEPTH registers to 0, overriding any simultaneous write.
REQ-029 While reset is high, bypass SHALL be disabled, so rd0, rd1 and rd_dbg show register contents, all 0 after the first reset edge.
REQ-030 Reset asserted mid-sequence SHALL discard the write of that cycle; the first write accepted is the one in the cycle after reset deasserts.
REQ-031 No output SHALL depend on reset except through register contents and REQ-029; there is no asynchronous path.

Verification
REQ-032 Reset, then read all addresses on both ports and debug -> every read returns 0.
REQ-033 Write 0xDEADBEEF to addr 5, next cycle ra0=5, ra1=5 -> rd0=rd1=0xDEADBEEF; rd_dbg with ra_dbg=5 -> 0xDEADBEEF.
REQ-034 ZERO_REG=1: write 0xFFFFFFFF to addr 0, read addr 0 -> 0 on all ports, same cycle and later.
REQ-035 BYPASS=1: addr 7 holds 0x11, we=1 wa=7 wd=0x22 ra0=7 -> rd0=0x22 same cycle, rd_dbg=0x11 until edge; BYPASS=0 -> rd0=0x11 until edge.
REQ-036 reset=1 together with we=1 wa=3 wd=0x55 -> register 3 = 0 after the edge; rd0 with ra0=3 reads 0 during reset.
REQ-037 Write addr 31 then addr 1 with distinct data, ADDR_WIDTH=5 -> both hold their own values, no aliasing.

Source files
------------

// File: rtl/register_file.sv
// register_file: multi-port register file with hardwired zero register and write-to-read bypass
module register_file #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic [ADDR_WIDTH-1:0] ra0,
  output logic [WIDTH-1:0]      rd0,
  input  logic [ADDR_WIDTH-1:0] ra1,
  output logic [WIDTH-1:0]      rd1,
  input  logic [ADDR_WIDTH-1:0] ra_dbg,
  output logic [WIDTH-1:0]      rd_dbg
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [WIDTH-1:0] regs [DEPTH];
  logic wa_zero;
  logic wr_ok;
  assign wa_zero = ZERO_REG && (wa == '0);
  assign wr_ok   = we && !wa_zero;
  // reset clears every register; otherwise commit a non-suppressed write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end
  // read muxes: zero register wins, then bypass (never during reset), then storage
  always_comb begin
    rd0    = (ZERO_REG && ra0 == '0) ? '0 :
             (BYPASS && wr_ok && !reset && ra0 == wa) ? wd : regs[ra0];
    rd1    = (ZERO_REG && ra1 == '0) ? '0 :
             (BYPASS && wr_ok && !reset && ra1 == wa) ? wd : regs[ra1];
    rd_dbg = (ZERO_REG && ra_dbg == '0) ? '0 : regs[ra_dbg];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file with bypass enabled and disabled
module tb_register_file;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0, ra0 = '0, ra1 = '0, ra_dbg = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd0, rd1, rd_dbg;
  logic [31:0] nb_rd0, nb_rd1, nb_rd_dbg;
  int checks = 0;
  int failures = 0;

  register_file dut (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .rd0(rd0), .ra1(ra1), .rd1(rd1), .ra_dbg(ra_dbg), .rd_dbg(rd_dbg)
  );

  register_file #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .rd0(nb_rd0), .ra1(ra1), .rd1(nb_rd1), .ra_dbg(ra_dbg), .rd_dbg(nb_rd_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_all(input logic [4:0] a);
    ra0 = a; ra1 = a; ra_dbg = a;
    #1;
  endtask

  initial begin
    step();
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    rd_all(5'd3);
    check("reset_bypass_off_rd0", rd0, 32'h0);
    check("reset_bypass_off_rd1", rd1, 32'h0);
    step();
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_all(5'(i));
      check($sformatf("reset_rd0_%0d", i), rd0, 32'h0);
      check($sformatf("reset_rd1_%0d", i), rd1, 32'h0);
      check($sformatf("reset_dbg_%0d", i), rd_dbg, 32'h0);
      check($sformatf("reset_nb_rd0_%0d", i), nb_rd0, 32'h0);
    end
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    rd_all(5'd5);
    check("w5_bypass_rd0", rd0, 32'hDEADBEEF);
    check("w5_bypass_rd1", rd1, 32'hDEADBEEF);
    check("w5_dbg_old", rd_dbg, 32'h0);
    check("w5_nb_old", nb_rd0, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("w5_rd0", rd0, 32'hDEADBEEF);
    check("w5_rd1", rd1, 32'hDEADBEEF);
    check("w5_dbg", rd_dbg, 32'hDEADBEEF);
    check("w5_nb_rd1", nb_rd1, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    rd_all(5'd0);
    check("zero_same_rd0", rd0, 32'h0);
    check("zero_same_rd1", rd1, 32'h0);
    check("zero_same_dbg", rd_dbg, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("zero_after_rd0", rd0, 32'h0);
    check("zero_after_dbg", rd_dbg, 32'h0);
    check("zero_after_nb", nb_rd_dbg, 32'h0);
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    step();
    wd = 32'h22;
    rd_all(5'd7);
    check("byp_rd0_new", rd0, 32'h22);
    check("byp_rd1_new", rd1, 32'h22);
    check("byp_dbg_old", rd_dbg, 32'h11);
    check("nb_rd0_old", nb_rd0, 32'h11);
    check("nb_rd1_old", nb_rd1, 32'h11);
    step();
    we = 1'b0;
    #1;
    check("byp_after_rd0", rd0, 32'h22);
    check("byp_after_dbg", rd_dbg, 32'h22);
    check("nb_after_rd0", nb_rd0, 32'h22);
    we = 1'b1; wa = 5'd31; wd = 32'hA5A5A5A5;
    step();
    wa = 5'd1; wd = 32'h5A5A5A5A;
    step();
    we = 1'b0; ra0 = 5'd31; ra1 = 5'd1; ra_dbg = 5'd5;
    #1;
    check("alias_31", rd0, 32'hA5A5A5A5);
    check("alias_1", rd1, 32'h5A5A5A5A);
    check("alias_5", rd_dbg, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd9; wd = 32'h1;
    step();
    wd = 32'h2; ra_dbg = 5'd9; ra0 = 5'd9;
    #1;
    check("b2b_first_dbg", rd_dbg, 32'h1);
    check("b2b_second_byp", rd0, 32'h2);
    step();
    we = 1'b0;
    #1;
    check("b2b_last_dbg", rd_dbg, 32'h2);
    wa = 5'd5; wd = 32'h0;
    step();
    rd_all(5'd5);
    check("we_low_hold", rd_dbg, 32'hDEADBEEF);
    reset = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'h77;
    #1;
    check("midreset_rd0_no_byp", rd0, 32'hDEADBEEF);
    check("midreset_rd1_no_byp", rd1, 32'hDEADBEEF);
    step();
    check("midreset_cleared", rd0, 32'h0);
    reset = 1'b0; wd = 32'h99;
    step();
    we = 1'b0;
    #1;
    check("post_reset_write", rd0, 32'h99);
    rd_all(5'd7);
    check("post_reset_7", rd_dbg, 32'h0);
    rd_all(5'd31);
    check("post_reset_31", rd1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
